// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//
// Watches a divided clock (e.g. ext_div5_seq_clk / ext_div5_cg_clk) as plain data in the
// ext_clk domain. It measures the rise-to-rise period and the high time in ext_clk cycles, and
// raises sticky errors when the period is out of tolerance or the divided clock stops toggling.
//
// Ports:
//   ext_clk      in   monitor clock
//   func_rst_n   in   asynchronous active-low reset
//   mon_en       in   monitor enable (level); low forces IDLE
//   div_clk_in   in   divided clock under observation (asynchronous data)
//   exp_period   in   expected period in ext_clk cycles; 0 disables all checks
//   period_tol   in   allowed absolute deviation of the measured period
//   err_clr      in   single-cycle pulse clearing the sticky errors
//   meas_valid   out  one-cycle pulse when meas_period / meas_high update
//   meas_period  out  last rise-to-rise period (saturating)
//   meas_high    out  sampled-high cycles in the last period (saturating)
//   period_err   out  sticky period-out-of-tolerance flag
//   stuck_err    out  sticky no-rising-edge-within-timeout flag
//   mon_state    out  0 = IDLE, 1 = ARM, 2 = RUN
//
// SYNC_STAGES must be in the range 2 to 4.

module clk_div_monitor #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ext_clk,
    input  logic             func_rst_n,
    input  logic             mon_en,
    input  logic             div_clk_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] period_tol,
    input  logic             err_clr,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             period_err,
    output logic             stuck_err,
    output logic [1:0]       mon_state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StRun  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Synchroniser plus one delay flop for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s_last;
    logic                   rise;

    always_ff @(posedge ext_clk or negedge func_rst_n) begin
        if (!func_rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];
    assign rise   = s_last & ~s_d_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d;
    logic             period_err_q, period_err_d;
    logic             stuck_err_q, stuck_err_d;

    // ------------------------------------------------------------------
    // Check arithmetic, one bit wider than the counters so nothing wraps
    // ------------------------------------------------------------------
    logic             checks_on;
    logic [CNT_W:0]   exp_x2;
    logic [CNT_W-1:0] timeout;
    logic             timeout_hit;
    logic [CNT_W:0]   meas_x;
    logic [CNT_W:0]   exp_x;
    logic [CNT_W:0]   diff;
    logic             out_of_tol;

    assign checks_on   = |exp_period;
    assign exp_x2      = {exp_period, 1'b0};
    assign timeout     = exp_x2[CNT_W] ? CntMax : exp_x2[CNT_W-1:0];
    // Rise wins over a coincident timeout.
    assign timeout_hit = checks_on && (cnt_q == timeout) && !rise;

    // The value being captured is cnt_q, so the check runs on it directly.
    assign meas_x     = {1'b0, cnt_q};
    assign exp_x      = {1'b0, exp_period};
    assign diff       = (meas_x >= exp_x) ? (meas_x - exp_x) : (exp_x - meas_x);
    assign out_of_tol = diff > {1'b0, period_tol};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic period_set;
    logic stuck_set;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_d        = high_q;
        meas_valid_d  = 1'b0;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        period_set    = 1'b0;
        stuck_set     = 1'b0;

        if (!mon_en) begin
            state_d = StIdle;
            cnt_d   = '0;
            high_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // The first ARM cycle already counts as one elapsed cycle.
                    state_d = StArm;
                    cnt_d   = CntOne;
                    high_d  = '0;
                end
                StArm: begin
                    if (rise) begin
                        state_d = StRun;
                        cnt_d   = CntOne;
                        high_d  = CntOne;
                    end else if (timeout_hit) begin
                        stuck_set = 1'b1;
                        cnt_d     = CntOne;
                        high_d    = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                StRun: begin
                    if (rise) begin
                        meas_valid_d  = 1'b1;
                        meas_period_d = cnt_q;
                        meas_high_d   = high_q;
                        period_set    = checks_on & out_of_tol;
                        // The rise cycle itself is sampled high.
                        cnt_d         = CntOne;
                        high_d        = CntOne;
                    end else if (timeout_hit) begin
                        stuck_set = 1'b1;
                        state_d   = StArm;
                        cnt_d     = CntOne;
                        high_d    = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                        if (s_last) begin
                            high_d = sat_inc(high_q);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    high_d  = '0;
                end
            endcase
        end

        // Setting an error wins over a coincident clear.
        period_err_d = period_set | (period_err_q & ~err_clr);
        stuck_err_d  = stuck_set  | (stuck_err_q  & ~err_clr);
    end

    always_ff @(posedge ext_clk or negedge func_rst_n) begin
        if (!func_rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            high_q        <= '0;
            meas_valid_q  <= 1'b0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            period_err_q  <= 1'b0;
            stuck_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_q        <= high_d;
            meas_valid_q  <= meas_valid_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            period_err_q  <= period_err_d;
            stuck_err_q   <= stuck_err_d;
        end
    end

    assign meas_valid  = meas_valid_q;
    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign period_err  = period_err_q;
    assign stuck_err   = stuck_err_q;
    assign mon_state   = state_q;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Clock-divider monitor in the ext_clk domain. It sits directly downstream of the lab divided-clock generators (ext_div5_seq_clk / ext_div5_cg_clk) and consumes one of them as a data signal. It synchronises that signal into ext_clk and measures its period and high time in ext_clk cycles. It flags sticky errors when the period is out of tolerance or when the divided clock stops toggling.

## Interface
- CNT_W, 8, width of all counters and measurement outputs
- SYNC_STAGES, 2, synchroniser depth on div_clk_in (legal range 2 to 4)

- ext_clk  in  1  monitor clock
- func_rst_n  in  1  reset, asynchronous, active-low
- mon_en  in  1  monitor enable, level
- div_clk_in  in  1  divided clock under observation, treated as a data signal
- exp_period  in  CNT_W  expected period in ext_clk cycles; 0 disables all checks
- period_tol  in  CNT_W  allowed absolute deviation of the measured period
- err_clr  in  1  single-cycle pulse that clears the sticky errors
- meas_valid  out  1  one-cycle pulse; meas_period and meas_high updated
- meas_period  out  CNT_W  last measured rise-to-rise period
- meas_high  out  CNT_W  sampled-high cycles in the last period
- period_err  out  1  sticky: a measured period was out of tolerance
- stuck_err  out  1  sticky: no rising edge seen within the timeout
- mon_state  out  2  current state: 0 = IDLE, 1 = ARM, 2 = RUN

## Operation
- Reset values: every output is 0, the state is IDLE, all counters are 0, and every synchroniser flop is 0.
- Synchroniser: SYNC_STAGES flops followed by one delay flop (s_d). The edge signal is rise = s_last & !s_d, computed combinationally from flops.
- State machine:
  - IDLE: counters held at 0. Goes to ARM when mon_en = 1.
  - ARM: cnt increments each cycle. On rise, goes to RUN with cnt = 1 and high_cnt = 1. No measurement is made.
  - RUN: on each non-rise cycle, cnt increments and high_cnt increments when s_last = 1. On rise, the block captures meas_period = cnt and meas_high = high_cnt, then reloads cnt = 1 and high_cnt = 1.
  - Any state: mon_en = 0 forces IDLE on the next cycle. Measurements and sticky errors hold their values.
- Saturation: cnt and high_cnt saturate at 2^CNT_W - 1 and never wrap. Captured values are therefore saturated too.
- Period check: computed on each capture in CNT_W+1-bit unsigned arithmetic as |meas_period - exp_period| > period_tol. It sets period_err when exp_period != 0.
- Timeout: timeout = 2*exp_period, computed in CNT_W+1 bits and clamped to 2^CNT_W - 1.
  - The timeout fires in ARM or RUN when cnt == timeout and rise = 0, provided exp_period != 0.
  - On firing, the block sets stuck_err, enters ARM and reloads cnt = 1.
- Sticky errors: set takes priority over err_clr in the same cycle. Errors clear only through err_clr or reset.
- exp_period and period_tol are sampled live. A change takes effect from the next cycle.

## Timing
- When div_clk_in is first seen high at posedge k, rise is asserted during cycle k + SYNC_STAGES - 1.
- meas_valid, meas_period, meas_high and period_err update at posedge k + SYNC_STAGES. meas_valid is high for exactly one cycle.
- stuck_err is registered on the posedge where cnt == timeout is detected.
- For a steady period P ≥ 2, meas_valid pulses every P cycles.
- The first capture occurs on the second rise after entering ARM.
- Reset asserted mid-operation clears all outputs asynchronously. After release, the state is IDLE, and ARM is entered on the first posedge with mon_en = 1.
- When rise and the timeout coincide, rise wins: a normal capture is made and stuck_err is not set.
- When rise and mon_en = 0 coincide: no capture, go to IDLE.

## Test plan
- Reset: assert func_rst_n = 0 mid-run with stuck_err = 1 and meas_period = 5 → all outputs read 0 immediately; mon_state = 0 after release.
- Nominal: div_clk_in = ext_clk/5 (2 high / 3 low, posedge-driven), exp_period = 5, period_tol = 0, mon_en = 1 →
  - from the second rise, meas_valid every 5 cycles with meas_period = 5 and meas_high = 2;
  - period_err = 0 and stuck_err = 0.
- Tolerance: div_clk_in period 7, exp_period = 5, period_tol = 1 →
  - period_err = 1 on the first meas_valid;
  - an err_clr pulse clears it, and it re-asserts on the next meas_valid (5 / 7 cycles later);
  - err_clr coincident with a failing capture leaves it at 1.
- Stuck: div_clk_in held 0, exp_period = 5 → stuck_err rises 10 cycles after entering ARM; mon_state stays 1 and cnt reloads to 1.
- Saturation: CNT_W = 4, div_clk_in period 20 (10 high), exp_period = 0 → meas_period = 15, meas_high = 10, no errors.
- Disable mid-period: mon_en dropped 3 cycles after a rise → mon_state = 0 next cycle; meas_* hold their previous values; no meas_valid pulse.
